// File: rtl/id_issue_scheduler.sv
// ID-stage issue/interlock controller: per-register countdown scoreboard, RAW stall,
// jump bubble and HALT drain. Define ID_ISSUE_FORWARD_EN to let a count of 1 bypass from EX.
module id_issue_scheduler #(
  parameter int unsigned NREG    = 32,
  parameter int unsigned WB_LAT  = 3,
  parameter int unsigned CNT_W   = 3,
  parameter int unsigned STALL_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [1:0]         id_type,
  input  logic [4:0]         id_rs,
  input  logic [4:0]         id_rt,
  input  logic [4:0]         id_rd,
  output logic               id_ready,
  output logic               issue,
  output logic [NREG-1:0]    busy_mask,
  output logic               halted,
  output logic [STALL_W-1:0] stall_cnt
);

  localparam logic [1:0] TYPE_R    = 2'd0;
  localparam logic [1:0] TYPE_J    = 2'd1;
  localparam logic [1:0] TYPE_HALT = 2'd2;
  localparam logic [1:0] TYPE_I    = 2'd3;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];
  logic [NREG-1:0]  busy_d;
  logic             hazard;
  logic             all_low;
  logic             stall_inc;
  logic             rs_used, rt_used, dst_we;
  logic [4:0]       dst;

  // A source blocks issue while its producer has not yet reached a readable point
  function automatic logic src_blocked(input logic [CNT_W-1:0] c);
`ifdef ID_ISSUE_FORWARD_EN
    return c > CNT_W'(1);
`else
    return c != '0;
`endif
  endfunction

  // Next-state, scoreboard update and combinational handshake
  always_comb begin
    state_d   = state_q;
    id_ready  = 1'b0;
    issue     = 1'b0;
    stall_inc = 1'b0;
    hazard    = 1'b0;
    all_low   = 1'b1;
    busy_d    = '0;
    rs_used   = (id_type == TYPE_R) || (id_type == TYPE_I);
    rt_used   = (id_type == TYPE_R);
    dst       = (id_type == TYPE_R) ? id_rd : id_rt;
    dst_we    = ((id_type == TYPE_R) || (id_type == TYPE_I)) && (dst != 5'd0);

    for (int unsigned n = 0; n < NREG; n++) begin
      cnt_d[n] = (cnt_q[n] != '0) ? cnt_q[n] - CNT_W'(1) : '0;
      if (cnt_q[n] > CNT_W'(1)) all_low = 1'b0;
    end

    if (rs_used && (id_rs != 5'd0) && src_blocked(cnt_q[id_rs])) hazard = 1'b1;
    if (rt_used && (id_rt != 5'd0) && src_blocked(cnt_q[id_rt])) hazard = 1'b1;

    case (state_q)
      ST_RUN:    id_ready = ~hazard;
      ST_FLUSH:  state_d = ST_RUN;
      ST_DRAIN:  if (all_low) state_d = ST_HALTED;
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_RUN;
    endcase

    if (!rst_n) id_ready = 1'b0;
    issue = id_valid & id_ready;

    // Issue only happens in RUN, so these override the RUN default
    if (issue) begin
      if (id_type == TYPE_J)    state_d = ST_FLUSH;
      if (id_type == TYPE_HALT) state_d = ST_DRAIN;
      if (dst_we) cnt_d[dst] = CNT_W'(WB_LAT);
    end

    stall_inc = id_valid && !id_ready && ((state_q == ST_RUN) || (state_q == ST_FLUSH));

    for (int unsigned n = 0; n < NREG; n++) busy_d[n] = (cnt_d[n] != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      for (int unsigned n = 0; n < NREG; n++) cnt_q[n] <= '0;
      busy_mask <= '0;
      halted    <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state_q   <= state_d;
      for (int unsigned n = 0; n < NREG; n++) cnt_q[n] <= cnt_d[n];
      busy_mask <= busy_d;
      halted    <= (state_d == ST_HALTED);
      if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + STALL_W'(1);
    end
  end

endmodule
